// File: rtl/azadi_pinmux_pkg.sv
// Shared constants for the Azadi pad multiplexer: register word indices and select encoding.
package azadi_pinmux_pkg;

    localparam int unsigned SEL_W = 2;
    localparam logic [SEL_W-1:0] FUNC_GPIO = '0;

    localparam logic [2:0] SEL0      = 3'd0;
    localparam logic [2:0] SEL1      = 3'd1;
    localparam logic [2:0] SEL2      = 3'd2;
    localparam logic [2:0] SEL3      = 3'd3;
    localparam logic [2:0] LOCK      = 3'd4;
    localparam logic [2:0] DB_THRESH = 3'd5;

    // Out-of-range selects fall back to GPIO so a pad is never left undriven.
    function automatic logic [SEL_W-1:0] eff_sel(input logic [SEL_W-1:0] sel,
                                                 input int unsigned num_alt);
        return (32'(sel) < num_alt) ? sel : FUNC_GPIO;
    endfunction

endpackage

// File: rtl/azadi_pinmux_filter.sv
// Per-pad input path: two-flop synchroniser followed by the debounce filter.
// Debounce counter is built only when AZADI_PINMUX_DEBOUNCE_EN is defined.
module azadi_pinmux_filter #(
    parameter int unsigned DB_CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pad,
    input  logic [DB_CNT_W-1:0] thresh,
    output logic                filt
);
    import azadi_pinmux_pkg::*;

    logic meta;
    logic sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= pad;
            sync <= meta;
        end
    end

`ifdef AZADI_PINMUX_DEBOUNCE_EN
    logic [DB_CNT_W-1:0] cnt;

    // ">=" rather than "==" so a threshold lowered below the running count still fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (sync == filt) begin
            cnt <= '0;
        end else if (cnt >= thresh) begin
            filt <= sync;
            cnt  <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh;

    always_ff @(posedge clk) begin
        if (rst) begin
            filt <= 1'b0;
        end else begin
            filt <= sync;
        end
    end
`endif

endmodule

// File: rtl/azadi_pinmux.sv
// Register-programmable pad multiplexer with write-once lock and filtered inputs.
// Define AZADI_PINMUX_DEBOUNCE_EN to build the debounce counters and DB_THRESH register.
module azadi_pinmux #(
    parameter int unsigned NUM_PADS = 38,
    parameter int unsigned NUM_ALT  = 4,
    parameter int unsigned DB_CNT_W = 8
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        reg_we,
    input  logic                        reg_re,
    input  logic [2:0]                  reg_addr,
    input  logic [31:0]                 reg_wdata,
    output logic [31:0]                 reg_rdata,
    output logic                        reg_rvalid,
    input  logic [NUM_PADS*NUM_ALT-1:0] func_o,
    input  logic [NUM_PADS*NUM_ALT-1:0] func_oe,
    output logic [NUM_PADS-1:0]         pad_in_o,
    input  logic [NUM_PADS-1:0]         io_in,
    output logic [NUM_PADS-1:0]         io_out,
    output logic [NUM_PADS-1:0]         io_oeb
);
    import azadi_pinmux_pkg::*;

    logic [SEL_W-1:0]    sel [NUM_PADS];
    logic [127:0]        sel_flat;
    logic                locked;
    logic [DB_CNT_W-1:0] db_thresh;
    logic [31:0]         rd_next;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            locked <= 1'b0;
        end else if (reg_we && reg_addr == LOCK && reg_wdata[0]) begin
            locked <= 1'b1;
        end
    end

`ifdef AZADI_PINMUX_DEBOUNCE_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            db_thresh <= '0;
        end else if (reg_we && reg_addr == DB_THRESH) begin
            db_thresh <= reg_wdata[DB_CNT_W-1:0];
        end
    end
`else
    assign db_thresh = '0;
`endif

    if (NUM_PADS < 64) begin : g_sel_fill
        assign sel_flat[127:2*NUM_PADS] = '0;
    end

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        logic [3:0]       alt_o;
        logic [3:0]       alt_oe;
        logic [SEL_W-1:0] eff;

        // Pad each pad's function group to four entries so the 2-bit select always fits.
        always_comb begin
            alt_o                = '0;
            alt_oe               = '0;
            alt_o[NUM_ALT-1:0]   = func_o[i*NUM_ALT +: NUM_ALT];
            alt_oe[NUM_ALT-1:0]  = func_oe[i*NUM_ALT +: NUM_ALT];
            eff                  = eff_sel(sel[i], NUM_ALT);
        end

        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) begin
                sel[i]    <= FUNC_GPIO;
                io_out[i] <= 1'b0;
                io_oeb[i] <= 1'b1;
            end else begin
                if (reg_we && !locked && reg_addr == 3'(i / 16)) begin
                    sel[i] <= reg_wdata[2*(i%16) +: SEL_W];
                end
                io_out[i] <= alt_o[eff];
                io_oeb[i] <= ~alt_oe[eff];
            end
        end

        assign sel_flat[2*i +: SEL_W] = sel[i];

        azadi_pinmux_filter #(
            .DB_CNT_W (DB_CNT_W)
        ) u_filter (
            .clk    (wb_clk_i),
            .rst    (wb_rst_i),
            .pad    (io_in[i]),
            .thresh (db_thresh),
            .filt   (pad_in_o[i])
        );
    end

    always_comb begin
        rd_next = '0;
        case (reg_addr)
            SEL0:      rd_next = sel_flat[31:0];
            SEL1:      rd_next = sel_flat[63:32];
            SEL2:      rd_next = sel_flat[95:64];
            SEL3:      rd_next = sel_flat[127:96];
            LOCK:      rd_next = {31'd0, locked};
            DB_THRESH: rd_next = 32'(db_thresh);
            default:   rd_next = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            reg_rdata  <= '0;
            reg_rvalid <= 1'b0;
        end else begin
            reg_rdata  <= reg_re ? rd_next : '0;
            reg_rvalid <= reg_re;
        end
    end

endmodule

// File: tb/tb_azadi_pinmux.sv
// Directed self-checking bench for azadi_pinmux (default 38x4 instance plus a 4x3 instance).
module tb_azadi_pinmux;

    localparam int unsigned NP  = 38;
    localparam int unsigned NA  = 4;
    localparam int unsigned NP3 = 4;
    localparam int unsigned NA3 = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          reg_we, reg_re;
    logic [2:0]    reg_addr;
    logic [31:0]   reg_wdata;
    logic [31:0]   rdata, rdata3;
    logic          rvalid, rvalid3;
    logic [NP*NA-1:0]   func_o, func_oe;
    logic [NP-1:0]      io_in, io_out, io_oeb, pad_in;
    logic [NP3*NA3-1:0] func_o3, func_oe3;
    logic [NP3-1:0]     io_in3, io_out3, io_oeb3, pad_in3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    azadi_pinmux dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (rdata),
        .reg_rvalid (rvalid),
        .func_o     (func_o),
        .func_oe    (func_oe),
        .pad_in_o   (pad_in),
        .io_in      (io_in),
        .io_out     (io_out),
        .io_oeb     (io_oeb)
    );

    azadi_pinmux #(
        .NUM_PADS (NP3),
        .NUM_ALT  (NA3),
        .DB_CNT_W (8)
    ) dut3 (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (rdata3),
        .reg_rvalid (rvalid3),
        .func_o     (func_o3),
        .func_oe    (func_oe3),
        .pad_in_o   (pad_in3),
        .io_in      (io_in3),
        .io_out     (io_out3),
        .io_oeb     (io_oeb3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        reg_we    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        @(negedge clk);
        reg_we    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        reg_re   = 1'b1;
        reg_addr = a;
        @(negedge clk);
        reg_re   = 1'b0;
        check({tag, "_rvalid"}, 64'(rvalid), 64'd1);
        check(tag, 64'(rdata), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        reg_we    = 1'b0;
        reg_re    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        func_o    = '0;
        func_oe   = '0;
        io_in     = '0;
        func_o3   = '0;
        func_oe3  = '0;
        io_in3    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_oeb",    64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
        check("rst_out",    64'(io_out), 64'd0);
        check("rst_pad_in", 64'(pad_in), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rdata",  64'(rdata),  64'd0);
        rd("rst_sel0", 3'd0, 32'd0);
        rd("rst_lock", 3'd4, 32'd0);
        rd("rst_db",   3'd5, 32'd0);
        @(negedge clk);
        check("rvalid_one_cycle", 64'(rvalid), 64'd0);

        // GPIO on pad 1: func -> pad in one cycle
        func_o[4]  = 1'b1;
        func_oe[4] = 1'b1;
        @(negedge clk);
        check("out_lat_o",  64'(io_out[1]), 64'd1);
        check("out_lat_oe", 64'(io_oeb[1]), 64'd0);

        // pad 0 -> function 2
        func_o[2]   = 1'b1;
        func_oe[2]  = 1'b1;
        func_o3[0]  = 1'b1;
        func_oe3[0] = 1'b1;
        func_oe3[2] = 1'b1;
        @(negedge clk);
        check("pre_sel_o", 64'(io_out[0]), 64'd0);
        wr(3'd0, 32'h0000_0002);
        @(negedge clk);
        check("sel2_o",   64'(io_out[0]),  64'd1);
        check("sel2_oe",  64'(io_oeb[0]),  64'd0);
        check("sel2_o3",  64'(io_out3[0]), 64'd0);
        check("sel2_oe3", 64'(io_oeb3[0]), 64'd0);

        // select 3: legal with 4 functions, falls back to GPIO with 3
        wr(3'd0, 32'h0000_0003);
        @(negedge clk);
        check("sel3_o",   64'(io_out[0]),  64'd0);
        check("sel3_oe",  64'(io_oeb[0]),  64'd1);
        check("sel3_o3",  64'(io_out3[0]), 64'd1);
        check("sel3_oe3", 64'(io_oeb3[0]), 64'd0);
        rd("sel3_rd", 3'd0, 32'h0000_0003);
        check("sel3_rd3", 64'(rdata3), 64'h3);

        // bits beyond the last pad read 0
        wr(3'd2, 32'hFFFF_FFFF);
        rd("word2_rd", 3'd2, 32'h0000_0FFF);
        check("word2_rd3", 64'(rdata3), 64'd0);
        wr(3'd3, 32'hFFFF_FFFF);
        rd("word3_rd", 3'd3, 32'd0);
        wr(3'd7, 32'hFFFF_FFFF);
        rd("addr7_rd", 3'd7, 32'd0);
        rd("addr6_rd", 3'd6, 32'd0);

        // simultaneous write and read returns the old value
        reg_we    = 1'b1;
        reg_re    = 1'b1;
        reg_addr  = 3'd1;
        reg_wdata = 32'h0000_0005;
        @(negedge clk);
        reg_we = 1'b0;
        reg_re = 1'b0;
        check("wr_rd_rvalid", 64'(rvalid), 64'd1);
        check("wr_rd_old",    64'(rdata),  64'd0);
        rd("wr_rd_new", 3'd1, 32'h0000_0005);

        // lock
        func_o[3] = 1'b1;
        wr(3'd4, 32'd1);
        @(negedge clk);
        check("lock_pre_o", 64'(io_out[0]), 64'd1);
        rd("lock_rd", 3'd4, 32'd1);
        wr(3'd0, 32'd0);
        rd("lock_sel_rd", 3'd0, 32'h0000_0003);
        check("lock_sel_rd3", 64'(rdata3), 64'h3);
        @(negedge clk);
        check("lock_mux_o", 64'(io_out[0]), 64'd1);

        // mid-operation reset clears everything, lock included
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst2_oeb", 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
        check("rst2_out", 64'(io_out), 64'd0);
        rd("rst2_lock", 3'd4, 32'd0);
        rd("rst2_sel0", 3'd0, 32'd0);
        rd("rst2_sel1", 3'd1, 32'd0);

`ifdef AZADI_PINMUX_DEBOUNCE_EN
        wr(3'd5, 32'd9);
        rd("db_rd", 3'd5, 32'd9);
        wr(3'd5, 32'd4);
        begin
            logic leaked;
            leaked = 1'b0;
            io_in[5] = 1'b1;
            repeat (3) @(negedge clk);
            io_in[5] = 1'b0;
            repeat (12) begin
                @(negedge clk);
                if (pad_in[5]) leaked = 1'b1;
            end
            check("db_glitch", 64'(leaked), 64'd0);
        end
        io_in[5] = 1'b1;
        repeat (6) @(negedge clk);
        check("db_edge6", 64'(pad_in[5]), 64'd0);
        @(negedge clk);
        check("db_edge7", 64'(pad_in[5]), 64'd1);
        check("db_vec",   64'(pad_in),    64'h20);
`else
        wr(3'd5, 32'd9);
        rd("db_rd", 3'd5, 32'd0);
        io_in[5] = 1'b1;
        repeat (2) @(negedge clk);
        check("in_rise2", 64'(pad_in[5]), 64'd0);
        @(negedge clk);
        check("in_rise3", 64'(pad_in[5]), 64'd1);
        check("in_vec",   64'(pad_in),    64'h20);
        io_in[5] = 1'b0;
        repeat (2) @(negedge clk);
        check("in_fall2", 64'(pad_in[5]), 64'd1);
        @(negedge clk);
        check("in_fall3", 64'(pad_in[5]), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
